// File: rtl/sonar_echo_emulator.sv
// ---------------------------------------------------------------------------
// sonar_echo_emulator
//
// Responder side of the ultrasonic ranging trigger/echo protocol. Watches the
// trigger line, qualifies its high time, waits out the acoustic-burst
// interval, drives echo high for a programmed width, then enforces a dead
// time before another shot can be accepted.
//
// Ports:
//   clk          in   system clock (50 MHz)
//   reset        in   asynchronous active-high reset
//   trigger      in   shot request from the sonar controller (asynchronous)
//   echo_cycles  in   [31:0] desired echo width, sampled when a shot is accepted
//   target_valid in   1 = object present, 0 = no return (timeout width used)
//   echo         out  emulated echo pulse (registered)
//   busy         out  high in every state except IDLE (registered)
//   trig_err     out  one-cycle pulse when a trigger high is too short
//   shot_count   out  [15:0] accepted shots, wraps modulo 2^16
// ---------------------------------------------------------------------------
module sonar_echo_emulator #(
   parameter logic [31:0] MIN_TRIG_CYCLES = 32'd500,
   parameter logic [31:0] BURST_CYCLES    = 32'd10000,
   parameter logic [31:0] TIMEOUT_CYCLES  = 32'd1900000,
   parameter logic [31:0] HOLDOFF_CYCLES  = 32'd3000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        trigger,
   input  logic [31:0] echo_cycles,
   input  logic        target_valid,
   output logic        echo,
   output logic        busy,
   output logic        trig_err,
   output logic [15:0] shot_count
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_TRIG_HIGH = 3'd1,
      ST_BURST     = 3'd2,
      ST_ECHO      = 3'd3,
      ST_HOLDOFF   = 3'd4
   } state_t;

   state_t      state_r;
   logic        sync1_r;
   logic        sync2_r;
   logic        level_r;
   logic        rise_r;
   logic        fall_r;
   logic [31:0] hi_cnt_r;
   logic [31:0] cnt_r;
   logic [31:0] width_r;
   logic [31:0] hi_next_s;
   logic [31:0] width_s;

   // Trigger synchronizer plus registered edge events; both events come from
   // the single synchronized bit, so rise and fall can never coincide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         level_r <= 1'b0;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
      end else begin
         sync1_r <= trigger;
         sync2_r <= sync1_r;
         level_r <= sync2_r;
         rise_r  <= sync2_r & ~level_r;
         fall_r  <= ~sync2_r & level_r;
      end
   end

   // Trigger high-time including the current cycle, saturating at the minimum.
   // Counting the fall cycle makes a pulse of exactly MIN_TRIG_CYCLES valid.
   always_comb begin
      if (hi_cnt_r >= MIN_TRIG_CYCLES) begin
         hi_next_s = MIN_TRIG_CYCLES;
      end else begin
         hi_next_s = hi_cnt_r + 32'd1;
      end
   end

   // Echo width chosen at shot acceptance: timeout when no target or a zero
   // request, otherwise the request clamped to the timeout.
   always_comb begin
      if (!target_valid || (echo_cycles == 32'd0)) begin
         width_s = TIMEOUT_CYCLES;
      end else if (echo_cycles > TIMEOUT_CYCLES) begin
         width_s = TIMEOUT_CYCLES;
      end else begin
         width_s = echo_cycles;
      end
   end

   // Shot sequencer with registered echo/busy/trig_err/shot_count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         hi_cnt_r   <= 32'd0;
         cnt_r      <= 32'd0;
         width_r    <= 32'd0;
         echo       <= 1'b0;
         busy       <= 1'b0;
         trig_err   <= 1'b0;
         shot_count <= 16'd0;
      end else begin
         trig_err <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (rise_r) begin
                  hi_cnt_r <= 32'd0;
                  busy     <= 1'b1;
                  state_r  <= ST_TRIG_HIGH;
               end
            end
            ST_TRIG_HIGH: begin
               hi_cnt_r <= hi_next_s;
               if (fall_r) begin
                  if (hi_next_s >= MIN_TRIG_CYCLES) begin
                     width_r    <= width_s;
                     shot_count <= shot_count + 16'd1;
                     cnt_r      <= 32'd0;
                     state_r    <= ST_BURST;
                  end else begin
                     trig_err <= 1'b1;
                     busy     <= 1'b0;
                     state_r  <= ST_IDLE;
                  end
               end
            end
            ST_BURST: begin
               if (cnt_r == (BURST_CYCLES - 32'd1)) begin
                  cnt_r   <= 32'd0;
                  echo    <= 1'b1;
                  state_r <= ST_ECHO;
               end else begin
                  cnt_r <= cnt_r + 32'd1;
               end
            end
            ST_ECHO: begin
               // width_r is never zero, so width_r - 1 cannot underflow.
               if (cnt_r == (width_r - 32'd1)) begin
                  cnt_r   <= 32'd0;
                  echo    <= 1'b0;
                  state_r <= ST_HOLDOFF;
               end else begin
                  cnt_r <= cnt_r + 32'd1;
               end
            end
            ST_HOLDOFF: begin
               if (cnt_r == (HOLDOFF_CYCLES - 32'd1)) begin
                  cnt_r   <= 32'd0;
                  busy    <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r + 32'd1;
               end
            end
            default: begin
               cnt_r   <= 32'd0;
               echo    <= 1'b0;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sonar_echo_emulator.sv
// ---------------------------------------------------------------------------
// tb_sonar_echo_emulator
//
// Directed plus randomized shots against sonar_echo_emulator with scaled-down
// timing parameters. A shot-level reference model predicts acceptance, echo
// rise time, echo width, holdoff end and shot count from the protocol rules.
// ---------------------------------------------------------------------------
module tb_sonar_echo_emulator;

   localparam int MIN   = 20;
   localparam int BURST = 50;
   localparam int TMO   = 300;
   localparam int HOLD  = 200;

   logic        clk = 1'b0;
   logic        reset;
   logic        trigger;
   logic [31:0] echo_cycles;
   logic        target_valid;
   logic        echo;
   logic        busy;
   logic        trig_err;
   logic [15:0] shot_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rise_at = 0;
   int fall_at = 0;
   int n_rise = 0;
   int n_fall = 0;
   int n_err = 0;
   int n_err_long = 0;
   int exp_count = 0;
   logic echo_q = 1'b0;
   logic err_q = 1'b0;

   sonar_echo_emulator #(
      .MIN_TRIG_CYCLES (MIN),
      .BURST_CYCLES    (BURST),
      .TIMEOUT_CYCLES  (TMO),
      .HOLDOFF_CYCLES  (HOLD)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .trigger      (trigger),
      .echo_cycles  (echo_cycles),
      .target_valid (target_valid),
      .echo         (echo),
      .busy         (busy),
      .trig_err     (trig_err),
      .shot_count   (shot_count)
   );

   // Clock generation.
   always #5 clk = ~clk;

   // Edge counter: cyc equals the number of the most recent rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor, sampled shortly after each active edge.
   always @(posedge clk) begin
      #2;
      if (echo && !echo_q) begin rise_at = cyc; n_rise++; end
      if (!echo && echo_q) begin fall_at = cyc; n_fall++; end
      if (trig_err && !err_q) n_err++;
      if (trig_err && err_q) n_err_long++;
      echo_q = echo;
      err_q  = trig_err;
   end

   // Reference width rule.
   function automatic int model_width(input logic [31:0] ec, input logic tv);
      if (!tv || ec == 32'd0) return TMO;
      if (ec > 32'(TMO)) return TMO;
      return int'(ec);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse(input int hi, output int fall_edge);
      @(negedge clk) trigger = 1'b1;
      repeat (hi) @(negedge clk);
      trigger = 1'b0;
      fall_edge = cyc + 1;
   endtask

   task automatic wait_echo_fall(input int f0);
      int k = 0;
      while (n_fall == f0 && k < BURST + TMO + 100) begin @(negedge clk); k++; end
   endtask

   task automatic wait_echo_rise(input int r0);
      int k = 0;
      while (n_rise == r0 && k < BURST + 100) begin @(negedge clk); k++; end
   endtask

   task automatic wait_idle(output int at);
      int k = 0;
      while (busy !== 1'b0 && k < BURST + TMO + HOLD + 100) begin @(negedge clk); k++; end
      at = cyc;
   endtask

   task automatic shot(input int hi, input logic [31:0] ec, input logic tv, input string tag);
      int fe, r0, f0, e0, idle_at;
      echo_cycles = ec;
      target_valid = tv;
      r0 = n_rise; f0 = n_fall; e0 = n_err;
      pulse(hi, fe);
      // Inputs changed after acceptance must not affect the shot.
      repeat (5) @(negedge clk);
      echo_cycles = $urandom;
      target_valid = 1'($urandom_range(1, 0));
      if (hi >= MIN) begin
         exp_count = (exp_count + 1) % 65536;
         wait_echo_fall(f0);
         check({tag, "_npulse"}, 32'(n_fall - f0), 32'd1);
         check({tag, "_rise"}, 32'(rise_at), 32'(fe + BURST + 3));
         check({tag, "_width"}, 32'(fall_at - rise_at), 32'(model_width(ec, tv)));
         check({tag, "_busy_holdoff"}, {31'd0, busy}, 32'd1);
         wait_idle(idle_at);
         check({tag, "_holdoff_end"}, 32'(idle_at), 32'(fall_at + HOLD));
         check({tag, "_no_err"}, 32'(n_err - e0), 32'd0);
      end else begin
         repeat (BURST + 10) @(negedge clk);
         check({tag, "_err_pulse"}, 32'(n_err - e0), 32'd1);
         check({tag, "_no_echo"}, 32'(n_rise - r0), 32'd0);
         check({tag, "_idle"}, {31'd0, busy}, 32'd0);
      end
      check({tag, "_count"}, {16'd0, shot_count}, 32'(exp_count));
   endtask

   initial begin
      int fe, dummy, at, r0, f0, e0, hi;
      logic [31:0] ec;
      logic tv;
      reset = 1'b1;
      trigger = 1'b0;
      echo_cycles = 32'd0;
      target_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_echo", {31'd0, echo}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_err", {31'd0, trig_err}, 32'd0);
      check("reset_count", {16'd0, shot_count}, 32'd0);
      @(negedge clk) reset = 1'b0;
      repeat (3) @(negedge clk);

      // Directed shots, including width-rule boundaries.
      shot(MIN, 32'd250, 1'b1, "nominal");
      shot(MIN + 3, 32'd120, 1'b1, "second");
      shot(MIN - 1, 32'd200, 1'b1, "short_by_one");
      shot(5, 32'd200, 1'b1, "short");
      shot(MIN, 32'd150, 1'b0, "no_target");
      shot(MIN, 32'd0, 1'b1, "zero_width");
      shot(MIN, 32'(TMO + 1000), 1'b1, "clamp");
      shot(MIN, 32'(TMO), 1'b1, "at_timeout");
      shot(MIN, 32'd1, 1'b1, "min_width");

      // Retrigger during ECHO and during HOLDOFF is ignored.
      echo_cycles = 32'd250; target_valid = 1'b1;
      r0 = n_rise; f0 = n_fall; e0 = n_err;
      pulse(MIN, fe);
      exp_count++;
      wait_echo_rise(r0);
      repeat (10) @(negedge clk);
      pulse(MIN + 5, dummy);
      wait_echo_fall(f0);
      check("retrig_npulse", 32'(n_fall - f0), 32'd1);
      check("retrig_rise", 32'(rise_at), 32'(fe + BURST + 3));
      check("retrig_width", 32'(fall_at - rise_at), 32'd250);
      repeat (20) @(negedge clk);
      pulse(MIN + 5, dummy);
      wait_idle(at);
      check("retrig_holdoff_end", 32'(at), 32'(fall_at + HOLD));
      repeat (20) @(negedge clk);
      check("retrig_nrise", 32'(n_rise - r0), 32'd1);
      check("retrig_no_err", 32'(n_err - e0), 32'd0);
      check("retrig_count", {16'd0, shot_count}, 32'(exp_count));

      // Trigger held high across the end of HOLDOFF starts nothing.
      echo_cycles = 32'd10;
      r0 = n_rise; f0 = n_fall;
      pulse(MIN, fe);
      exp_count++;
      wait_echo_fall(f0);
      repeat (20) @(negedge clk);
      trigger = 1'b1;
      wait_idle(at);
      check("held_holdoff_end", 32'(at), 32'(fall_at + HOLD));
      repeat (50) @(negedge clk);
      check("held_idle", {31'd0, busy}, 32'd0);
      check("held_nrise", 32'(n_rise - r0), 32'd1);
      check("held_count", {16'd0, shot_count}, 32'(exp_count));
      trigger = 1'b0;
      repeat (10) @(negedge clk);
      shot(MIN, 32'd80, 1'b1, "after_held");

      // Randomized shots around the minimum trigger width.
      for (int i = 0; i < 8; i++) begin
         hi = $urandom_range(MIN + 10, MIN - 4);
         if ($urandom_range(3, 0) == 0) ec = 32'(TMO) + 32'($urandom_range(500, 1));
         else ec = 32'($urandom_range(TMO, 0));
         tv = ($urandom_range(3, 0) != 0);
         shot(hi, ec, tv, "rand");
      end

      // Reset in the middle of an echo.
      echo_cycles = 32'(TMO); target_valid = 1'b1;
      r0 = n_rise;
      pulse(MIN, fe);
      wait_echo_rise(r0);
      repeat (100) @(negedge clk);
      check("pre_reset_echo", {31'd0, echo}, 32'd1);
      reset = 1'b1;
      #1;
      check("midreset_echo", {31'd0, echo}, 32'd0);
      check("midreset_busy", {31'd0, busy}, 32'd0);
      check("midreset_count", {16'd0, shot_count}, 32'd0);
      exp_count = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      shot(MIN, 32'd250, 1'b1, "post_reset");

      check("err_pulse_width", 32'(n_err_long), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sonar_echo_emulator.md
Name: sonar_echo_emulator

Overview:
- Synthesizable model of the ultrasonic ranging module. It is the responder side of the trigger/echo protocol that the sonar measurement block drives.
- It watches the `trigger` line, waits for the acoustic-burst interval, then drives `echo` high for a programmed number of clock cycles.
- Used for hardware-in-loop bring-up of the sonar path and as a bench model in place of the physical sensor.
- Same 50 MHz clock domain as the measurement block.

Parameters:
- MIN_TRIG_CYCLES, 500: minimum `trigger` high time (10 us at 50 MHz) for a valid shot.
- BURST_CYCLES, 10000: delay from accepted trigger fall to `echo` rise (8-pulse burst, 200 us).
- TIMEOUT_CYCLES, 1900000: no-target echo width (38 ms); also the upper clamp on echo width.
- HOLDOFF_CYCLES, 3000000: dead time after `echo` falls (60 ms), during which triggers are ignored.

Ports:
- clk, input, 1: system clock, 50 MHz.
- reset, input, 1: asynchronous, active-high reset.
- trigger, input, 1: shot request from the sonar controller.
- echo_cycles, input, 32: desired echo high time in clock cycles, sampled at shot acceptance.
- target_valid, input, 1: 1 = object present; 0 = no echo return, so the timeout width is used.
- echo, output, 1: emulated echo pulse, registered.
- busy, output, 1: high in every state except IDLE.
- trig_err, output, 1: one-cycle pulse when a `trigger` high is shorter than MIN_TRIG_CYCLES.
- shot_count, output, 16: number of accepted shots; wraps modulo 2^16.

Behaviour:
- Reset values: echo=0, busy=0, trig_err=0, shot_count=0, state=IDLE, all counters 0, synchronizer flops 0. Reset asserted mid-shot forces `echo` low immediately (asynchronous).
- Trigger conditioning: 2-flop synchronizer, then one edge register. Rise and fall events appear 3 cycles after the input change.
- IDLE: on synchronized rise, clear hi_cnt and go to TRIG_HIGH.
- TRIG_HIGH:
  - hi_cnt increments each cycle and saturates at MIN_TRIG_CYCLES.
  - On synchronized fall with hi_cnt >= MIN_TRIG_CYCLES, accept the shot:
    - latch width W;
    - shot_count +1;
    - clear cnt;
    - go to BURST.
  - On synchronized fall with hi_cnt < MIN_TRIG_CYCLES: trig_err=1 for exactly one cycle, go to IDLE, no other effect.
- Width rule, evaluated at acceptance:
  - W = TIMEOUT_CYCLES if target_valid=0 or echo_cycles=0;
  - else W = min(echo_cycles, TIMEOUT_CYCLES).
  - Later changes to echo_cycles or target_valid do not affect the shot in progress.
- BURST: count BURST_CYCLES cycles, then set echo=1 and go to ECHO. Net timing: `echo` rises BURST_CYCLES+3 cycles after the first clk edge that samples trigger=0.
- ECHO: `echo` stays high for exactly W cycles, then echo=0 and go to HOLDOFF.
- HOLDOFF: count HOLDOFF_CYCLES cycles, then go to IDLE.
- A new shot requires a fresh synchronized rise observed in IDLE. `trigger` held high across the end of HOLDOFF does not start a shot.
- Trigger activity in BURST, ECHO or HOLDOFF is ignored. It sets no trig_err and does not restart timing.
- Simultaneous rise and fall in one cycle cannot occur, because events are derived from a single synchronized bit.
- Counters are 32 bits. No arithmetic overflow is possible within the clamp limits.
- busy=1 from the cycle TRIG_HIGH is entered until the cycle IDLE is re-entered.

Test Plan:
- Nominal 30 ms shot: trigger high 500 cycles, echo_cycles=1500000, target_valid=1 -> `echo` rises 10003 cycles after trigger falls, high exactly 1500000 cycles; shot_count=1; the downstream sonar block reads distance 1500000.
- Second shot: after holdoff, echo_cycles=500000 -> echo high exactly 500000 cycles; shot_count=2.
- Short trigger: trigger high 100 cycles -> trig_err high for 1 cycle, echo stays 0, shot_count unchanged, busy returns to 0.
- No target: target_valid=0, echo_cycles=1500000 -> echo width 1900000. Separately, echo_cycles=5000000 with target_valid=1 -> width clamped to 1900000.
- Retrigger: trigger pulsed 500 cycles during ECHO and again during HOLDOFF -> no change to echo timing, shot_count +1 only. Trigger held high through the end of HOLDOFF -> no new shot until it falls and rises again.
- Reset mid-ECHO: assert reset 200000 cycles into the echo -> echo=0 in the same cycle, busy=0, shot_count=0. After release, a nominal shot behaves as in the first scenario.
